// File: rtl/gost89_pkg.sv
// rtl/gost89_pkg.sv - shared constants and helpers for the GOST 28147-89 round function
package gost89_pkg;

    localparam logic [63:0] SBOX_IDENTITY_ROW = 64'h0123456789ABCDEF;

    // Destination bit position of source bit i after a left rotate by r over w bits.
    function automatic int rotl_bit_index(input int i, input int w, input int r);
        return (i + r) % w;
    endfunction

    // Entry idx of a row lives at bits [63-4*idx : 60-4*idx].
    function automatic logic [3:0] row_select(input logic [63:0] row, input logic [3:0] idx);
        logic [63:0] shifted;
        shifted = row << {idx, 2'b00};
        return shifted[63:60];
    endfunction

endpackage

// File: rtl/gost89_sbox_row.sv
// rtl/gost89_sbox_row.sv - one 16-entry 4-bit S-box row register with lookup
// Reset contents: identity row when GOST89_DEFAULT_SBOX_EN is defined, else zero and unloaded.
module gost89_sbox_row
    import gost89_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [63:0] data_i,
    input  logic [3:0]  idx_i,
    output logic [3:0]  sub_o,
    output logic        loaded_o
);

    logic [63:0] row_q;
    logic [63:0] row_d;
    logic        loaded_q;
    logic        loaded_d;

    always_comb begin
        row_d    = row_q;
        loaded_d = loaded_q;
        if (we_i) begin
            row_d    = data_i;
            loaded_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef GOST89_DEFAULT_SBOX_EN
            row_q    <= SBOX_IDENTITY_ROW;
            loaded_q <= 1'b1;
`else
            row_q    <= 64'h0;
            loaded_q <= 1'b0;
`endif
        end else begin
            row_q    <= row_d;
            loaded_q <= loaded_d;
        end
    end

    assign sub_o    = row_select(row_q, idx_i);
    assign loaded_o = loaded_q;

endmodule

// File: rtl/gost89_round.sv
// rtl/gost89_round.sv - two-stage pipelined GOST 28147-89 round function (add, S-box, rotate)
// Optional GOST89_DEFAULT_SBOX_EN preloads identity S-box rows at reset.
module gost89_round
    import gost89_pkg::*;
#(
    parameter  int NSBOX = 8,
    parameter  int ROT   = 11,
    localparam int DW    = 4 * NSBOX,
    localparam int AW    = (NSBOX > 1) ? $clog2(NSBOX) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [63:0]   cfg_data,
    output logic          cfg_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_sum_q,   s1_sum_d;
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_data_q,  s2_data_d;
    logic          run_q;

    logic [NSBOX-1:0] row_we;
    logic [NSBOX-1:0] loaded_w;
    logic [DW-1:0]    sub_w;
    logic [DW-1:0]    rot_w;
    logic             tables_loaded;
    logic             s2_adv;
    logic             in_fire;

    for (genvar k = 0; k < NSBOX; k++) begin : g_row
        assign row_we[k] = cfg_we && cfg_ready && (cfg_addr == AW'(k));

        gost89_sbox_row u_row (
            .clk      (clk),
            .rst_n    (rst_n),
            .we_i     (row_we[k]),
            .data_i   (cfg_data),
            .idx_i    (s1_sum_q[4*k +: 4]),
            .sub_o    (sub_w[4*k +: 4]),
            .loaded_o (loaded_w[k])
        );
    end

    always_comb begin
        rot_w = '0;
        for (int i = 0; i < DW; i++) begin
            rot_w[rotl_bit_index(i, DW, ROT)] = sub_w[i];
        end
    end

    // run_q keeps in_ready low during reset even when tables come up preloaded.
    always_comb begin
        tables_loaded = &loaded_w;
        s2_adv        = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready      = run_q && tables_loaded && (!s1_valid_q || s2_adv);
        in_fire       = in_valid && in_ready;
        cfg_ready     = !s1_valid_q && !s2_valid_q && !in_valid;

        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = in_data + in_key;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = rot_w;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            run_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            run_q      <= 1'b1;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

endmodule

// File: tb/tb_gost89_round.sv
// tb/tb_gost89_round.sv - directed self-checking bench for gost89_round (default build)
module tb_gost89_round;

    localparam logic [63:0] ID_ROW   = 64'h0123456789ABCDEF;
    localparam logic [63:0] ONES_ROW = 64'hFFFFFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [63:0] cfg_data = 64'h0;
    logic        cfg_ready;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [31:0] in_key = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    gost89_round #(.NSBOX(8), .ROT(11)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Identity-row model: substitution leaves the sum unchanged, then rotl 11.
    function automatic logic [31:0] model_id(input logic [31:0] d, input logic [31:0] k);
        logic [31:0] s;
        s = d + k;
        return (s << 11) | (s >> 21);
    endfunction

    task automatic write_row(input logic [2:0] a, input logic [63:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic write_all(input logic [63:0] d);
        for (int r = 0; r < 8; r++) write_row(3'(r), d);
    endtask

    task automatic run_one(input string tag, input logic [31:0] d, input logic [31:0] k,
                           input logic [31:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_key    = k;
        settle();
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        settle();
        chk({tag, "_valid_c1"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid_c2"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, exp);
        tick();
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    task automatic stream(input string tag, input bit toggle);
        logic [31:0] exp_q[$];
        logic [31:0] d;
        logic [31:0] k;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        while (got < 16 && cyc < 300) begin
            d         = 32'(sent) * 32'h01234567 + (toggle ? 32'h5A5A0000 : 32'h0);
            k         = 32'h0F0F0F0F ^ 32'(sent);
            in_valid  = (sent < 16);
            in_data   = d;
            in_key    = k;
            out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            settle();
            if (in_valid && in_ready) begin
                exp_q.push_back(model_id(d, k));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk({tag, "_spurious"}, out_data, 32'hx);
                else chk({tag, "_data"}, out_data, exp_q.pop_front());
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, 32'(got), 32'd16);
        if (!toggle) chk({tag, "_span"}, 32'(last - first), 32'd15);
        settle();
        chk({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        tick();
        settle();
        chk("no_tables_in_ready", 32'(in_ready), 32'd0);

        // Table load: in_ready rises only after the last row
        for (int r = 0; r < 7; r++) begin
            write_row(3'(r), ID_ROW);
            settle();
            chk("load_partial_in_ready", 32'(in_ready), 32'd0);
        end
        write_row(3'd7, ID_ROW);
        settle();
        chk("load_full_in_ready", 32'(in_ready), 32'd1);

        run_one("basic", 32'h00000001, 32'h00000001, 32'h00001000);
        run_one("wrap", 32'hFFFFFFFF, 32'h00000002, 32'h00000800);
        run_one("mixed", 32'h12345678, 32'h11111111, 32'h2B3C491A);

        // Config write colliding with an input: input wins, row 0 stays identity
        cfg_we    = 1'b1;
        cfg_addr  = 3'd0;
        cfg_data  = ONES_ROW;
        in_valid  = 1'b1;
        in_data   = 32'h0;
        in_key    = 32'h0;
        out_ready = 1'b1;
        settle();
        chk("clash_cfg_ready", 32'(cfg_ready), 32'd0);
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("clash_valid", 32'(out_valid), 32'd1);
        chk("clash_data", out_data, 32'h0);
        tick();
        run_one("clash_row_kept", 32'h0, 32'h0, 32'h0);

        write_all(ONES_ROW);
        run_one("ones_rows", 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF);
        write_all(64'h0);
        run_one("zero_rows", 32'hDEADBEEF, 32'h01020304, 32'h00000000);
        write_all(ID_ROW);

        stream("stream_toggle", 1'b1);
        stream("stream_full", 1'b0);

        // Reset with both stages full: nothing may come out afterwards
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h00000005;
        in_key    = 32'h00000007;
        tick();
        tick();
        settle();
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        rst_n     = 1'b0;
        settle();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("post_rst_no_output", 32'(out_valid), 32'd0);
            tick();
        end
        chk("post_rst_tables_cleared", 32'(in_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
